dm_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller between the RISC-V core's data port and `slow_memory`. It is the initiator side of the slow-memory handshake. It serves 32-bit word hits with zero stall and converts misses into 128-bit block transfers, holding `mem_read`/`mem_write` asserted until `mem_ready` is seen. It runs on posedge `clk`; `slow_memory` runs on negedge of the same clock.

---
 rtl/dm_cache_ctrl_if.sv | 46 ++++
 rtl/dm_cache_ctrl.sv | 158 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_if.sv
// Bundles the core data port and the slow-memory block port of the cache controller.
// The master modport belongs to the controller; the slave modport is the core + memory side.
interface dm_cache_ctrl_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        input  proc_read,
        input  proc_write,
        input  proc_addr,
        input  proc_wdata,
        output proc_rdata,
        output proc_stall,
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        output proc_read,
        output proc_write,
        output proc_addr,
        output proc_wdata,
        input  proc_rdata,
        input  proc_stall,
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache between the core data port and slow_memory.
// Hits complete with zero stall; misses become 128-bit block writeback and fill transfers.
module dm_cache_ctrl #(
    parameter int BLOCK_NUM = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_cache_ctrl_if.master bus
);
    localparam int IW = $clog2(BLOCK_NUM);
    localparam int TW = 28 - IW;

    localparam logic [1:0] S_COMPARE   = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [BLOCK_NUM-1:0] valid_vec;
    logic [BLOCK_NUM-1:0] dirty_vec;
    logic [TW-1:0]        tag_arr  [BLOCK_NUM];
    logic [127:0]         data_arr [BLOCK_NUM];

    logic [IW-1:0]  idx;
    logic [TW-1:0]  tag_in;
    logic [1:0]     word_sel;
    logic [TW-1:0]  line_tag;
    logic [127:0]   line_data;
    logic           hit;
    logic           req;
    logic           in_compare;
    logic           hit_write;
    logic           wb_done;
    logic           fill_done;

    assign idx       = bus.proc_addr[IW+1:2];
    assign tag_in    = bus.proc_addr[29:IW+2];
    assign word_sel  = bus.proc_addr[1:0];
    assign line_tag  = tag_arr[idx];
    assign line_data = data_arr[idx];

    assign hit        = valid_vec[idx] && (line_tag == tag_in);
    assign req        = bus.proc_read || bus.proc_write;
    assign in_compare = (state_reg == S_COMPARE);
    // A simultaneous read+write request is handled as a write.
    assign hit_write  = in_compare && hit && bus.proc_write;
    assign wb_done    = (state_reg == S_WRITEBACK) && bus.mem_ready;
    assign fill_done  = (state_reg == S_ALLOCATE) && bus.mem_ready;

    assign bus.proc_stall = req && !(in_compare && hit);
    assign bus.mem_read   = (state_reg == S_ALLOCATE);
    assign bus.mem_write  = (state_reg == S_WRITEBACK);
    assign bus.mem_wdata  = (state_reg == S_WRITEBACK) ? line_data : 128'd0;

    always_comb begin
        bus.proc_rdata = 32'd0;
        if (bus.proc_read && !bus.proc_stall) begin
            bus.proc_rdata = line_data[{word_sel, 5'b0} +: 32];
        end
    end

    // Address comes from held core inputs and the untouched line, so it is stable per residency.
    always_comb begin
        bus.mem_addr = 28'd0;
        case (state_reg)
            S_WRITEBACK: bus.mem_addr = {line_tag, idx};
            S_ALLOCATE:  bus.mem_addr = bus.proc_addr[29:2];
            default:     bus.mem_addr = 28'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_COMPARE: begin
                if (req && !hit) begin
                    if (valid_vec[idx] && dirty_vec[idx]) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (bus.mem_ready) begin
                    state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (bus.mem_ready) begin
                    state_next = S_COMPARE;
                end
            end
            default: state_next = S_COMPARE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_COMPARE;
        end else begin
            state_reg <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_NUM; gi++) begin : g_line
            logic          sel;
            logic          valid_reg;
            logic          dirty_reg;
            logic [TW-1:0] tag_reg;
            logic [127:0]  data_reg;
            logic [127:0]  data_next;

            assign sel           = (idx == IW'(gi));
            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
            assign tag_arr[gi]   = tag_reg;
            assign data_arr[gi]  = data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (sel) begin
                    if (fill_done) begin
                        valid_reg <= 1'b1;
                        dirty_reg <= 1'b0;
                    end else if (wb_done) begin
                        dirty_reg <= 1'b0;
                    end else if (hit_write) begin
                        dirty_reg <= 1'b1;
                    end
                end
            end

            always_comb begin
                data_next = data_reg;
                if (fill_done) begin
                    data_next = bus.mem_rdata;
                end else if (hit_write) begin
                    data_next[{word_sel, 5'b0} +: 32] = bus.proc_wdata;
                end
            end

            // Tag and data carry no reset; valid_reg alone decides whether they mean anything.
            always_ff @(posedge clk) begin
                if (sel && (fill_done || hit_write)) begin
                    data_reg <= data_next;
                end
                if (sel && fill_done) begin
                    tag_reg <= tag_in;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a negedge-clocked slow-memory model.
// Each task drives one scenario and checks its own hand-computed results.
module tb_dm_cache_ctrl;
    localparam int LAT = 3;

    logic clk;
    logic rst_n;
    dm_cache_ctrl_if bus ();

    dm_cache_ctrl #(.BLOCK_NUM(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model state and transfer log.
    logic [31:0]  mem_words [0:1023];
    logic         busy = 1'b0;
    logic         busy_is_write = 1'b0;
    logic [27:0]  busy_addr = '0;
    logic [127:0] busy_wdata = '0;
    int           lat_cnt = 0;
    int           seq = 0;
    int           rd_done = 0;
    int           wr_done = 0;
    int           ready_pulses = 0;
    int           last_rd_seq = 0;
    int           last_wr_seq = 0;
    logic [27:0]  last_rd_addr = '0;
    logic [27:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    int           stable_err = 0;
    int           both_err = 0;
    int           traffic_cycles = 0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    end

    // Transfer starts at the negedge that first sees a request; ready pulses LAT+1 negedges later.
    always @(negedge clk) begin
        bus.mem_ready = 1'b0;
        if (busy) begin
            if ((bus.mem_read || bus.mem_write) &&
                (bus.mem_addr !== busy_addr || (busy_is_write && bus.mem_wdata !== busy_wdata))) begin
                stable_err++;
            end
            if (lat_cnt == 0) begin
                busy = 1'b0;
                seq++;
                ready_pulses++;
                if (busy_is_write) begin
                    for (int k = 0; k < 4; k++) begin
                        mem_words[int'(busy_addr[7:0]) * 4 + k] = busy_wdata[32*k +: 32];
                    end
                    wr_done++;
                    last_wr_addr = busy_addr;
                    last_wr_data = busy_wdata;
                    last_wr_seq  = seq;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        bus.mem_rdata[32*k +: 32] = mem_words[int'(busy_addr[7:0]) * 4 + k];
                    end
                    rd_done++;
                    last_rd_addr = busy_addr;
                    last_rd_seq  = seq;
                end
                bus.mem_ready = 1'b1;
            end else begin
                lat_cnt--;
            end
        end else if (bus.mem_read || bus.mem_write) begin
            busy          = 1'b1;
            busy_is_write = bus.mem_write;
            busy_addr     = bus.mem_addr;
            busy_wdata    = bus.mem_wdata;
            lat_cnt       = LAT;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_read && bus.mem_write) both_err++;
        if (bus.mem_read || bus.mem_write) traffic_cycles++;
    end

    // Present a request one tick after a posedge and wait (bounded) for stall to drop.
    task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rdata, output logic timeout);
        @(posedge clk);
        #1;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        stalls  = 0;
        timeout = 1'b0;
        #2;
        while (bus.proc_stall) begin
            stalls++;
            if (stalls > 200) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            #3;
        end
        rdata = bus.proc_rdata;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        #3;
        tests_run++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'd0) begin
            tests_failed++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h expected 0 0 0", bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        tests_run++;
        if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: stall=%b rdata=%h expected 0 0", bus.proc_stall, bus.proc_rdata);
        end
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h10;
        #1;
        tests_run++;
        if (bus.proc_stall !== 1'b1 || bus.proc_rdata !== 32'd0 || bus.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: stall=%b rdata=%h mem_read=%b expected 1 0 0",
                     bus.proc_stall, bus.proc_rdata, bus.mem_read);
        end
        bus.proc_read = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int rd0 = rd_done;
        int wr0 = wr_done;
        access(1'b1, 1'b0, 30'h10, 32'd0, stalls, rdata, to);
        tests_run++;
        if (to !== 1'b0 || rdata !== 32'hA5A5_0010 || stalls != 6) begin
            tests_failed++;
            $display("FAIL clean_miss_read: rdata=%h stalls=%0d to=%b expected a5a50010 6 0", rdata, stalls, to);
        end
        tests_run++;
        if (rd_done - rd0 != 1 || wr_done - wr0 != 0 || last_rd_addr !== 28'h4) begin
            tests_failed++;
            $display("FAIL clean_miss_traffic: reads=%0d writes=%0d addr=%h expected 1 0 0000004",
                     rd_done - rd0, wr_done - wr0, last_rd_addr);
        end
        access(1'b1, 1'b0, 30'h11, 32'd0, stalls, rdata, to);
        tests_run++;
        if (rdata !== 32'hA5A5_0011 || stalls != 0 || bus.mem_addr !== 28'd0) begin
            tests_failed++;
            $display("FAIL repeat_hit: rdata=%h stalls=%0d mem_addr=%h expected a5a50011 0 0", rdata, stalls, bus.mem_addr);
        end
        idle();
    endtask

    task automatic test_write_hit();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int t0 = traffic_cycles;
        access(1'b0, 1'b1, 30'h12, 32'hDEAD_BEEF, stalls, rdata, to);
        tests_run++;
        if (stalls != 0) begin
            tests_failed++;
            $display("FAIL write_hit_stall: stalls=%0d expected 0", stalls);
        end
        access(1'b1, 1'b0, 30'h12, 32'd0, stalls, rdata, to);
        tests_run++;
        if (rdata !== 32'hDEAD_BEEF || stalls != 0) begin
            tests_failed++;
            $display("FAIL write_hit_readback: rdata=%h stalls=%0d expected deadbeef 0", rdata, stalls);
        end
        idle();
        tests_run++;
        if (traffic_cycles != t0 || dut.dirty_vec[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_hit_state: traffic=%0d dirty4=%b expected 0 1", traffic_cycles - t0, dut.dirty_vec[4]);
        end
    endtask

    task automatic test_dirty_miss();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int rd0 = rd_done;
        int wr0 = wr_done;
        access(1'b1, 1'b0, 30'h212, 32'd0, stalls, rdata, to);
        tests_run++;
        if (to !== 1'b0 || rdata !== 32'hA5A5_0212 || stalls != 11) begin
            tests_failed++;
            $display("FAIL dirty_miss_read: rdata=%h stalls=%0d to=%b expected a5a50212 11 0", rdata, stalls, to);
        end
        tests_run++;
        if (wr_done - wr0 != 1 || last_wr_addr !== 28'h4 || last_wr_data[95:64] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL writeback: writes=%0d addr=%h word2=%h expected 1 0000004 deadbeef",
                     wr_done - wr0, last_wr_addr, last_wr_data[95:64]);
        end
        tests_run++;
        if (last_wr_data !== {32'hA5A5_0013, 32'hDEAD_BEEF, 32'hA5A5_0011, 32'hA5A5_0010}) begin
            tests_failed++;
            $display("FAIL writeback_block: got %h", last_wr_data);
        end
        tests_run++;
        if (rd_done - rd0 != 1 || last_rd_addr !== 28'h84 || last_rd_seq != last_wr_seq + 1) begin
            tests_failed++;
            $display("FAIL refill: reads=%0d addr=%h seq=%0d/%0d expected 1 0000084 write-then-read",
                     rd_done - rd0, last_rd_addr, last_wr_seq, last_rd_seq);
        end
        tests_run++;
        if (mem_words[18] !== 32'hDEAD_BEEF || dut.dirty_vec[4] !== 1'b0) begin
            tests_failed++;
            $display("FAIL dirty_miss_mem: mem[0x12]=%h dirty4=%b expected deadbeef 0", mem_words[18], dut.dirty_vec[4]);
        end
        idle();
    endtask

    task automatic test_write_miss();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int rd0 = rd_done;
        int wr0 = wr_done;
        access(1'b0, 1'b1, 30'h30, 32'h1234_5678, stalls, rdata, to);
        tests_run++;
        if (to !== 1'b0 || stalls != 6 || rd_done - rd0 != 1 || wr_done - wr0 != 0 || last_rd_addr !== 28'hC) begin
            tests_failed++;
            $display("FAIL write_miss_alloc: stalls=%0d reads=%0d writes=%0d addr=%h expected 6 1 0 000000c",
                     stalls, rd_done - rd0, wr_done - wr0, last_rd_addr);
        end
        access(1'b1, 1'b0, 30'h30, 32'd0, stalls, rdata, to);
        tests_run++;
        if (rdata !== 32'h1234_5678 || stalls != 0) begin
            tests_failed++;
            $display("FAIL write_miss_commit: rdata=%h stalls=%0d expected 12345678 0", rdata, stalls);
        end
        wr0 = wr_done;
        access(1'b1, 1'b0, 30'h10, 32'd0, stalls, rdata, to);
        tests_run++;
        if (wr_done - wr0 != 1 || last_wr_addr !== 28'hC ||
            last_wr_data !== {32'hA5A5_0033, 32'hA5A5_0032, 32'hA5A5_0031, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL write_miss_evict: writes=%0d addr=%h data=%h", wr_done - wr0, last_wr_addr, last_wr_data);
        end
        tests_run++;
        if (rdata !== 32'hA5A5_0010 || mem_words[48] !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL write_miss_mem: rdata=%h mem[0x30]=%h expected a5a50010 12345678", rdata, mem_words[48]);
        end
        idle();
    endtask

    task automatic test_reset_mid_allocate();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int rd0;
        int pulses0;
        int waited = 0;
        @(posedge clk);
        #1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h100;
        #2;
        while (!bus.mem_read && waited < 20) begin
            waited++;
            @(posedge clk);
            #3;
        end
        tests_run++;
        if (bus.mem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_alloc_enter: mem_read=%b expected 1", bus.mem_read);
        end
        @(negedge clk);
        #1;
        pulses0 = ready_pulses;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'd0 || dut.valid_vec !== 8'h00 ||
            bus.proc_stall !== 1'b1 || bus.proc_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: mem_read=%b addr=%h valid=%h stall=%b rdata=%h expected 0 0 00 1 0",
                     bus.mem_read, bus.mem_addr, dut.valid_vec, bus.proc_stall, bus.proc_rdata);
        end
        bus.proc_read = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        waited = 0;
        while (ready_pulses == pulses0 && waited < 20) begin
            waited++;
            @(posedge clk);
            #3;
        end
        @(posedge clk);
        #3;
        tests_run++;
        if (ready_pulses == pulses0 || dut.valid_vec !== 8'h00 || bus.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ready: pulses=%0d valid=%h mem_read=%b expected >0 00 0",
                     ready_pulses - pulses0, dut.valid_vec, bus.mem_read);
        end
        rd0 = rd_done;
        access(1'b1, 1'b0, 30'h100, 32'd0, stalls, rdata, to);
        tests_run++;
        if (rd_done - rd0 != 1 || rdata !== 32'hA5A5_0100 || last_rd_addr !== 28'h40) begin
            tests_failed++;
            $display("FAIL post_reset_miss: reads=%0d rdata=%h addr=%h expected 1 a5a50100 0000040",
                     rd_done - rd0, rdata, last_rd_addr);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int stalls;
        logic [31:0] rdata;
        logic to;
        int t0;
        for (int i = 0; i < 8; i++) begin
            access(1'b1, 1'b0, 30'(i * 4), 32'd0, stalls, rdata, to);
        end
        idle();
        t0 = traffic_cycles;
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, 30'(i * 4 + i % 4), 32'hC0DE_0000 + i, stalls, rdata, to);
            tests_run++;
            if (stalls != 0) begin
                tests_failed++;
                $display("FAIL b2b_write[%0d]: stalls=%0d expected 0", i, stalls);
            end
        end
        for (int i = 0; i < 8; i++) begin
            access(1'b1, 1'b0, 30'(i * 4 + i % 4), 32'd0, stalls, rdata, to);
            tests_run++;
            if (stalls != 0 || rdata !== 32'hC0DE_0000 + i) begin
                tests_failed++;
                $display("FAIL b2b_read[%0d]: rdata=%h stalls=%0d expected %h 0", i, rdata, stalls, 32'hC0DE_0000 + i);
            end
        end
        idle();
        tests_run++;
        if (traffic_cycles != t0) begin
            tests_failed++;
            $display("FAIL b2b_traffic: cycles=%0d expected 0", traffic_cycles - t0);
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (both_err != 0 || stable_err != 0) begin
            tests_failed++;
            $display("FAIL protocol: both_high=%0d unstable=%0d expected 0 0", both_err, stable_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_words[i] = 32'hA5A5_0000 + i;
        end
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_miss();
        test_write_miss();
        test_reset_mid_allocate();
        test_back_to_back();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
